// File: rtl/snake_body_queue.sv
// snake_body_queue: circular buffer of snake segments. Checks each new head
// for self-collision, then sequences erase-tail / draw-head plot commands.
module snake_body_queue #(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 80,
    parameter int INIT_Y   = 60,
    parameter int SEG_STEP = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       step_valid,
    output logic       step_ready,
    input  logic [7:0] head_x,
    input  logic [6:0] head_y,
    input  logic       grow,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_x,
    output logic [6:0] cmd_y,
    output logic       cmd_erase,
    output logic       done,
    output logic       collide,
    output logic [6:0] length
);
    localparam int PW = $clog2(MAX_LEN);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ERASE,
        S_DRAW,
        S_COMMIT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [14:0]   r_mem [MAX_LEN];
    logic [PW-1:0] r_head_ptr;
    logic [PW-1:0] r_tail_ptr;
    logic [PW-1:0] r_scan_idx;
    logic [6:0]    r_length;
    logic [6:0]    r_scan_cnt;
    logic [7:0]    r_nh_x;
    logic [6:0]    r_nh_y;
    logic          r_nh_g;
    logic          r_hit;
    logic          r_done;
    logic          r_collide;
    logic [7:0]    r_cmd_x;
    logic [6:0]    r_cmd_y;
    logic          r_cmd_erase;

    logic [PW-1:0] w_head_nxt;
    logic [14:0]   w_nh;
    logic [14:0]   w_scan_ent;
    logic [14:0]   w_tail_ent;
    logic          w_hs;
    logic          w_first;
    logic          w_last;
    logic          w_match;
    logic          w_hit_any;

    function automatic logic [14:0] init_ent(input int k);
        if (k < INIT_LEN)
            return {8'(INIT_X - (INIT_LEN - 1 - k) * SEG_STEP), 7'(INIT_Y)};
        return '0;
    endfunction

    assign w_head_nxt = r_head_ptr + P_ONE;
    assign w_nh       = {r_nh_x, r_nh_y};
    assign w_scan_ent = r_mem[r_scan_idx];
    assign w_tail_ent = r_mem[r_tail_ptr];
    assign w_hs       = step_valid && step_ready;
    assign w_first    = (r_scan_cnt == r_length);
    assign w_last     = (r_scan_cnt == 7'd1);
    // The tail vacates on a non-grow step, so it cannot be hit.
    assign w_match    = (w_scan_ent == w_nh) && !(w_first && !r_nh_g);
    assign w_hit_any  = r_hit || w_match;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_hs) w_next = S_SCAN;
            S_SCAN: begin
                if (w_last) begin
                    if (w_hit_any)   w_next = S_IDLE;
                    else if (r_nh_g) w_next = S_DRAW;
                    else             w_next = S_ERASE;
                end
            end
            S_ERASE:  if (cmd_ready) w_next = S_DRAW;
            S_DRAW:   if (cmd_ready) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        step_ready = (r_state == S_IDLE) && !r_collide;
        cmd_valid  = (r_state == S_ERASE) || (r_state == S_DRAW);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < MAX_LEN; k++)
                r_mem[k] <= init_ent(k);
        end else if (r_state == S_COMMIT) begin
            r_mem[w_head_nxt] <= w_nh;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head_ptr  <= PW'(INIT_LEN - 1);
            r_tail_ptr  <= '0;
            r_length    <= 7'(INIT_LEN);
            r_scan_idx  <= '0;
            r_scan_cnt  <= '0;
            r_nh_x      <= '0;
            r_nh_y      <= '0;
            r_nh_g      <= 1'b0;
            r_hit       <= 1'b0;
            r_done      <= 1'b0;
            r_collide   <= 1'b0;
            r_cmd_x     <= '0;
            r_cmd_y     <= '0;
            r_cmd_erase <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_nh_x     <= head_x;
                        r_nh_y     <= head_y;
                        r_nh_g     <= grow && (r_length != 7'(MAX_LEN));
                        r_scan_idx <= r_tail_ptr;
                        r_scan_cnt <= r_length;
                        r_hit      <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_scan_idx <= r_scan_idx + P_ONE;
                    r_scan_cnt <= r_scan_cnt - 7'd1;
                    r_hit      <= w_hit_any;
                    if (w_last) begin
                        if (w_hit_any) begin
                            r_collide <= 1'b1;
                            r_done    <= 1'b1;
                        end else if (r_nh_g) begin
                            r_cmd_x     <= r_nh_x;
                            r_cmd_y     <= r_nh_y;
                            r_cmd_erase <= 1'b0;
                        end else begin
                            {r_cmd_x, r_cmd_y} <= w_tail_ent;
                            r_cmd_erase        <= 1'b1;
                        end
                    end
                end
                S_ERASE: begin
                    if (cmd_ready) begin
                        r_cmd_x     <= r_nh_x;
                        r_cmd_y     <= r_nh_y;
                        r_cmd_erase <= 1'b0;
                    end
                end
                S_COMMIT: begin
                    r_head_ptr <= w_head_nxt;
                    if (r_nh_g)
                        r_length <= r_length + 7'd1;
                    else
                        r_tail_ptr <= r_tail_ptr + P_ONE;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_x     = r_cmd_x;
    assign cmd_y     = r_cmd_y;
    assign cmd_erase = r_cmd_erase;
    assign done      = r_done;
    assign collide   = r_collide;
    assign length    = r_length;

endmodule

// File: tb/tb_snake_body_queue.sv
// tb_snake_body_queue: directed table, corner sequences and randomized steps
// checked against a queue-based model of the snake body.
module tb_snake_body_queue;
    localparam int MAXL = 32;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       step_valid = 1'b0;
    logic       step_ready;
    logic [7:0] head_x = '0;
    logic [6:0] head_y = '0;
    logic       grow = 1'b0;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;
    logic [7:0] cmd_x;
    logic [6:0] cmd_y;
    logic       cmd_erase;
    logic       done;
    logic       collide;
    logic [6:0] length;

    int errors = 0;
    int checks = 0;

    logic [14:0] body[$];
    bit          mcol;

    always #5 clk = ~clk;

    snake_body_queue #(
        .MAX_LEN(32), .INIT_LEN(3), .INIT_X(80), .INIT_Y(60), .SEG_STEP(4)
    ) dut (
        .clk(clk), .resetn(resetn),
        .step_valid(step_valid), .step_ready(step_ready),
        .head_x(head_x), .head_y(head_y), .grow(grow),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_erase(cmd_erase),
        .done(done), .collide(collide), .length(length)
    );

    typedef struct {
        bit         rst;
        logic [7:0] x;
        logic [6:0] y;
        bit         g;
        int         ncmd;
        logic [7:0] ex;
        logic [6:0] ey;
        int         len;
        bit         col;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step_valid = 1'b0;
        grow = 1'b0;
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic model_reset();
        body.delete();
        for (int i = 2; i >= 0; i--)
            body.push_back({8'(80 - 4 * i), 7'd60});
        mcol = 1'b0;
    endtask

    task automatic run_step(
        input  logic [7:0]  x,
        input  logic [6:0]  y,
        input  logic        g,
        input  bit          rnd,
        output int          ncmd,
        output logic [14:0] c0,
        output logic        c0e,
        output logic [14:0] c1,
        output logic        c1e,
        output int          lat,
        output bit          tmo
    );
        int k;
        ncmd = 0; c0 = '0; c1 = '0; c0e = 1'b0; c1e = 1'b0;
        lat = -1; tmo = 1'b0; k = 0;
        while (!step_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!step_ready) begin
            tmo = 1'b1;
            return;
        end
        step_valid = 1'b1;
        head_x = x;
        head_y = y;
        grow = g;
        @(negedge clk);
        step_valid = 1'b0;
        grow = 1'b0;
        k = 0;
        while (1) begin
            if (done) begin
                lat = k;
                break;
            end
            if (k >= 300) begin
                tmo = 1'b1;
                break;
            end
            cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cmd_valid && cmd_ready) begin
                if (ncmd == 0) begin
                    c0 = {cmd_x, cmd_y};
                    c0e = cmd_erase;
                end else if (ncmd == 1) begin
                    c1 = {cmd_x, cmd_y};
                    c1e = cmd_erase;
                end
                ncmd++;
            end
            @(negedge clk);
            k++;
        end
        cmd_ready = 1'b1;
    endtask

    task automatic step_and_check(
        input logic [7:0] x, input logic [6:0] y, input logic g, input bit rnd
    );
        int          n, lat, len0, exp_lat;
        logic [14:0] c0, c1, nh, etail;
        logic        c0e, c1e;
        bit          tmo, eg, hit;
        nh = {x, y};
        len0 = body.size();
        eg = g && (len0 < MAXL);
        hit = 1'b0;
        for (int j = (eg ? 0 : 1); j < len0; j++)
            if (body[j] == nh) hit = 1'b1;
        etail = body[0];
        run_step(x, y, g, rnd, n, c0, c0e, c1, c1e, lat, tmo);
        chk("step_timeout", tmo, 0);
        if (hit) begin
            chk("col_ncmd", n, 0);
            chk("col_flag", collide, 1);
            exp_lat = len0;
            mcol = 1'b1;
        end else begin
            if (!eg) begin
                chk("ncmd", n, 2);
                chk("erase_xy", c0, etail);
                chk("erase_flag", c0e, 1);
                chk("draw_xy", c1, nh);
                chk("draw_flag", c1e, 0);
                void'(body.pop_front());
                exp_lat = len0 + 3;
            end else begin
                chk("ncmd_grow", n, 1);
                chk("draw_xy_grow", c0, nh);
                chk("draw_flag_grow", c0e, 0);
                exp_lat = len0 + 2;
            end
            body.push_back(nh);
            chk("no_collide", collide, 0);
        end
        chk("length", length, body.size());
        if (!rnd) chk("latency", lat, exp_lat);
    endtask

    initial begin
        vec_t        tv[6];
        int          n, lat, k, dir;
        logic [14:0] c0, c1, h;
        logic        c0e, c1e;
        bit          tmo, stable;
        logic [7:0]  hx, sx;
        logic [6:0]  hy, sy;

        tv[0] = '{1'b1, 8'd84, 7'd60, 1'b0, 2, 8'd72, 7'd60, 3, 1'b0, 6};
        tv[1] = '{1'b1, 8'd84, 7'd60, 1'b1, 1, 8'd0,  7'd0,  4, 1'b0, 5};
        tv[2] = '{1'b0, 8'd88, 7'd60, 1'b0, 2, 8'd72, 7'd60, 4, 1'b0, 7};
        tv[3] = '{1'b1, 8'd72, 7'd60, 1'b0, 2, 8'd72, 7'd60, 3, 1'b0, 6};
        tv[4] = '{1'b1, 8'd72, 7'd60, 1'b1, 0, 8'd0,  7'd0,  3, 1'b1, 3};
        tv[5] = '{1'b1, 8'd76, 7'd60, 1'b0, 0, 8'd0,  7'd0,  3, 1'b1, 3};

        do_reset();
        chk("rst_length", length, 3);
        chk("rst_collide", collide, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", step_ready, 1);
        chk("rst_cmd_xy", {cmd_x, cmd_y}, 0);
        chk("rst_cmd_erase", cmd_erase, 0);

        for (int i = 0; i < 6; i++) begin
            if (tv[i].rst) do_reset();
            run_step(tv[i].x, tv[i].y, tv[i].g, 1'b0,
                     n, c0, c0e, c1, c1e, lat, tmo);
            chk($sformatf("tv%0d_timeout", i), tmo, 0);
            chk($sformatf("tv%0d_ncmd", i), n, tv[i].ncmd);
            if (tv[i].ncmd == 2) begin
                chk($sformatf("tv%0d_erase_xy", i), c0, {tv[i].ex, tv[i].ey});
                chk($sformatf("tv%0d_erase_flag", i), c0e, 1);
                chk($sformatf("tv%0d_draw_xy", i), c1, {tv[i].x, tv[i].y});
                chk($sformatf("tv%0d_draw_flag", i), c1e, 0);
            end else if (tv[i].ncmd == 1) begin
                chk($sformatf("tv%0d_draw_xy", i), c0, {tv[i].x, tv[i].y});
                chk($sformatf("tv%0d_draw_flag", i), c0e, 0);
            end
            chk($sformatf("tv%0d_length", i), length, tv[i].len);
            chk($sformatf("tv%0d_collide", i), collide, tv[i].col);
            chk($sformatf("tv%0d_latency", i), lat, tv[i].lat);
            chk($sformatf("tv%0d_ready", i), step_ready, !tv[i].col);
            @(negedge clk);
            chk($sformatf("tv%0d_done_pulse", i), done, 0);
        end

        // Plotter stalls in ERASE: command must hold still.
        do_reset();
        cmd_ready = 1'b0;
        step_valid = 1'b1; head_x = 8'd84; head_y = 7'd60; grow = 1'b0;
        @(negedge clk);
        step_valid = 1'b0;
        k = 0;
        while (!cmd_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("stall_reach_erase", cmd_valid, 1);
        sx = cmd_x; sy = cmd_y; stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!cmd_valid || cmd_x != sx || cmd_y != sy || !cmd_erase)
                stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_erase_xy", {sx, sy}, {8'd72, 7'd60});
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("stall_adv_draw", cmd_erase, 0);
        chk("stall_draw_xy", {cmd_x, cmd_y}, {8'd84, 7'd60});
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("stall_done", done, 1);
        chk("stall_length", length, 3);

        // Fill to capacity, then a grow request must behave as a plain move.
        do_reset();
        model_reset();
        for (int i = 0; i < 29; i++)
            step_and_check(8'(84 + 4 * i), 7'd60, 1'b1, 1'b0);
        chk("full_length", length, MAXL);
        for (int i = 0; i < 4; i++)
            step_and_check(8'(200 + 4 * i), 7'd60, 1'b1, 1'b0);
        chk("full_length_kept", length, MAXL);

        // Reset while scanning.
        do_reset();
        step_valid = 1'b1; head_x = 8'd84; head_y = 7'd60; grow = 1'b0;
        @(negedge clk);
        step_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rscan_length", length, 3);
        chk("rscan_cmd_valid", cmd_valid, 0);
        chk("rscan_done", done, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        model_reset();
        step_and_check(8'd84, 7'd60, 1'b0, 1'b0);

        // Reset while DRAW is stalled.
        do_reset();
        step_valid = 1'b1; head_x = 8'd84; head_y = 7'd60; grow = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        grow = 1'b0;
        k = 0;
        while (!(cmd_valid && !cmd_erase) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rdraw_reach", cmd_valid && !cmd_erase, 1);
        cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rdraw_held", cmd_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rdraw_cmd_valid", cmd_valid, 0);
        chk("rdraw_cmd_xy", {cmd_x, cmd_y}, 0);
        chk("rdraw_cmd_erase", cmd_erase, 0);
        chk("rdraw_length", length, 3);
        chk("rdraw_done", done, 0);
        @(negedge clk);
        resetn = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        model_reset();
        step_and_check(8'd84, 7'd60, 1'b0, 1'b0);

        // Randomized walk against the body model.
        do_reset();
        model_reset();
        for (int i = 0; i < 200; i++) begin
            if (mcol) begin
                chk("rand_ready_after_col", step_ready, 0);
                do_reset();
                model_reset();
            end
            h = body[body.size() - 1];
            hx = h[14:7];
            hy = h[6:0];
            dir = int'($urandom_range(0, 3));
            case (dir)
                0: hx = hx + 8'd4;
                1: hx = hx - 8'd4;
                2: hy = hy + 7'd4;
                default: hy = hy - 7'd4;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                h = body[$urandom_range(0, body.size() - 1)];
                hx = h[14:7];
                hy = h[6:0];
            end
            step_and_check(hx, hy, ($urandom_range(0, 2) == 0), i[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_body_queue.md
Name: snake_body_queue

Overview:
Circular buffer of snake segment origins that sits between the movement/direction logic and the 4x4 block plotter. On each step it accepts the new head coordinate and checks it against the stored body for self-collision. It then issues an erase-tail command and a draw-head command to the plotter, and commits the queue update. It owns body length, growth and the sticky self-collision flag.

Parameters:
MAX_LEN, 32, queue depth in segments; must be a power of 2, range 4..64
INIT_LEN, 3, length after reset; 1 <= INIT_LEN <= MAX_LEN
INIT_X, 80, x of head after reset
INIT_Y, 60, y of all initial segments
SEG_STEP, 4, x spacing of initial segments; segment i (0 = head) is at (INIT_X - i*SEG_STEP, INIT_Y)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
step_valid  in  1  new head offered
step_ready  out  1  queue can accept a step
head_x  in  8  new head x, sampled when step_valid&&step_ready
head_y  in  7  new head y, sampled with head_x
grow  in  1  sampled with head; keep the tail this step (food eaten)
cmd_valid  out  1  plot command pending to block plotter
cmd_ready  in  1  plotter accepts command
cmd_x  out  8  block origin x
cmd_y  out  7  block origin y
cmd_erase  out  1  1 = paint black (tail), 0 = paint colour (head)
done  out  1  one-cycle pulse when step fully processed
collide  out  1  sticky self-collision flag
length  out  7  current segment count

Behaviour:
- Storage: MAX_LEN x 15-bit register array, head_ptr, tail_ptr. Pointers wrap modulo MAX_LEN by natural overflow.
- Reset (async, resetn=0):
  - state=IDLE; length=INIT_LEN; head_ptr=INIT_LEN-1; tail_ptr=0.
  - Entry k holds segment (INIT_LEN-1-k), giving the initial layout.
  - collide=0, done=0, cmd_valid=0, cmd_x=0, cmd_y=0, cmd_erase=0.
  - Reset mid-operation abandons the step immediately; no partial commit.
- FSM states: IDLE, SCAN, ERASE, DRAW, COMMIT.
- IDLE:
  - step_ready = !collide.
  - On handshake, latch head_x/head_y/grow into nh_x/nh_y/nh_g.
  - If grow && length==MAX_LEN, force nh_g=0 (full queue never grows).
  - Load scan index = tail_ptr, scan count = length; go to SCAN.
- SCAN: one entry per cycle, from tail toward head, exactly `length` cycles.
  - Tail entry (first cycle) is excluded from comparison when nh_g=0, because it vacates this step.
  - Any match of both x and y sets hit.
  - After the last entry: if hit, set collide=1, pulse done, return to IDLE with no commands and no update. Otherwise go to ERASE if nh_g=0, or DRAW if nh_g=1.
- ERASE: cmd_valid=1, cmd_erase=1, cmd_x/cmd_y = tail entry. Hold outputs stable until cmd_ready, then go to DRAW.
- DRAW: cmd_valid=1, cmd_erase=0, cmd_x/cmd_y = nh. Hold until cmd_ready, then go to COMMIT.
- Command rule: cmd_valid is asserted only in ERASE and DRAW. The command transfers on the cycle cmd_valid&&cmd_ready, and cmd_valid drops in the following state.
- COMMIT (1 cycle):
  - head_ptr+=1; write nh at the new head_ptr.
  - If nh_g=0, tail_ptr+=1; else length+=1.
  - done=1 this cycle; go to IDLE.
- Latency: with cmd_ready held high, step handshake to done = length + 3 cycles (non-grow) or length + 2 cycles (grow).
- step_valid outside IDLE is ignored (step_ready=0). collide is cleared only by reset; while set, step_ready stays 0.
- No bounds checking on coordinates. Wall collision belongs upstream.

Test Plan:
- Reset with defaults; step head=(84,60), grow=0, cmd_ready=1 -> ERASE cmd (72,60,erase=1), then DRAW cmd (84,60,erase=0); done 6 cycles after handshake; length=3.
- Step head=(84,60), grow=1 -> only DRAW cmd (84,60); done after 5 cycles; length=4; next non-grow step erases (72,60).
- Step head=(72,60) onto the tail with grow=0 -> no collision (tail excluded), erase (72,60), draw (72,60); with grow=1 instead -> collide=1, no cmd_valid, done pulses, step_ready stays 0.
- Hold cmd_ready=0 for 10 cycles in ERASE -> cmd_valid, cmd_x, cmd_y stable throughout; state advances only on the ready cycle.
- Grow until length=32, then step with grow=1 -> treated as non-grow (ERASE issued, length stays 32); head_ptr wraps from 31 to 0 correctly.
- Assert resetn=0 during SCAN and during DRAW with cmd_ready=0 -> outputs return to reset values asynchronously; next step behaves as after the first reset.
